// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and the IF/ID pipeline register.
// Handles stall/flush redirection and a two-state RUN/HALT machine.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | fetching sequentially, PC advances by 2 per accepted fetch
// HALT  | HLT was fetched; PC frozen, IF/ID fed with bubbles until flush
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] flush_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] IF_ID_instr,
  output logic [15:0] IF_ID_PC_next,
  output logic        IF_ID_valid,
  output logic [7:0]  IF_ID_tag,
  output logic [7:0]  fetch_id,
  output logic        halted
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        is_hlt;

  assign pc_plus2  = pc + 16'd2;
  assign is_hlt    = (imem_data[15:12] == HLT_OPCODE);
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_RUN;
      pc            <= RESET_PC;
      IF_ID_instr   <= NOP_INSTR;
      IF_ID_PC_next <= 16'h0000;
      IF_ID_valid   <= 1'b0;
      IF_ID_tag     <= 8'h00;
      fetch_id      <= 8'h00;
    end else if (flush) begin
      // Redirect wins over stall; IF_ID_PC_next and fetch_id intentionally keep their values.
      state       <= S_RUN;
      pc          <= flush_target;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
      IF_ID_tag   <= 8'h00;
    end else if (!stall) begin
      case (state)
        S_RUN: begin
          IF_ID_instr   <= imem_data;
          IF_ID_PC_next <= pc_plus2;
          IF_ID_valid   <= 1'b1;
          IF_ID_tag     <= fetch_id;
          fetch_id      <= fetch_id + 8'd1;
          if (is_hlt) begin
            state <= S_HALT;
          end else begin
            pc <= pc_plus2;
          end
        end
        S_HALT: begin
          IF_ID_instr <= NOP_INSTR;
          IF_ID_valid <= 1'b0;
          IF_ID_tag   <= 8'h00;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized stall/flush/halt traffic against a fetch model.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [3:0]  HLT_OP    = 4'hF;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] flush_target;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] IF_ID_instr;
  logic [15:0] IF_ID_PC_next;
  logic        IF_ID_valid;
  logic [7:0]  IF_ID_tag;
  logic [7:0]  fetch_id;
  logic        halted;

  logic [15:0] mem [0:32767];
  assign imem_data = mem[imem_addr[15:1]];

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .HLT_OPCODE(HLT_OP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_target(flush_target),
    .imem_data(imem_data), .imem_addr(imem_addr), .IF_ID_instr(IF_ID_instr),
    .IF_ID_PC_next(IF_ID_PC_next), .IF_ID_valid(IF_ID_valid), .IF_ID_tag(IF_ID_tag),
    .fetch_id(fetch_id), .halted(halted)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Architectural view of the fetch stage
  logic [15:0] m_pc, m_instr, m_pcn;
  logic        m_valid, m_halt;
  logic [7:0]  m_tag, m_fid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_pcn = 16'h0000;
    m_valid = 1'b0; m_tag = 8'h00; m_fid = 8'h00; m_halt = 1'b0;
  endtask

  function automatic void bubble();
    m_instr = NOP_INSTR; m_valid = 1'b0; m_tag = 8'h00;
  endfunction

  task automatic model_step();
    logic [15:0] word;
    if (flush) begin
      m_pc = flush_target; m_halt = 1'b0; bubble();
    end else if (stall) begin
      // frozen
    end else if (m_halt) begin
      bubble();
    end else begin
      word    = mem[m_pc[15:1]];
      m_instr = word;
      m_pcn   = m_pc + 16'd2;
      m_valid = 1'b1;
      m_tag   = m_fid;
      m_fid   = m_fid + 8'd1;
      if (word[15:12] == HLT_OP) m_halt = 1'b1;
      else m_pc = m_pc + 16'd2;
    end
  endtask

  always @(posedge clk) if (!rst) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", imem_addr, m_pc);
      check("IF_ID_instr", IF_ID_instr, m_instr);
      check("IF_ID_PC_next", IF_ID_PC_next, m_pcn);
      check("IF_ID_valid", {15'd0, IF_ID_valid}, {15'd0, m_valid});
      check("IF_ID_tag", {8'd0, IF_ID_tag}, {8'd0, m_tag});
      check("fetch_id", {8'd0, fetch_id}, {8'd0, m_fid});
      check("halted", {15'd0, halted}, {15'd0, m_halt});
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;
    int n;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_target = 16'h0000;
    for (int i = 0; i < 32768; i++) begin
      rnd = $urandom;
      mem[i] = {4'($urandom_range(0, 14)), rnd[11:0]};
    end
    mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h3789;
    for (int i = 3; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8] = 16'h2ABC;
    mem[32767] = 16'h1234;

    #1 rst = 1'b1; model_reset();
    #1;
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_instr", IF_ID_instr, NOP_INSTR);
    check("rst_pcn", IF_ID_PC_next, 16'h0000);
    check("rst_valid", {15'd0, IF_ID_valid}, 16'h0000);
    check("rst_tag", {8'd0, IF_ID_tag}, 16'h0000);
    check("rst_fid", {8'd0, fetch_id}, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'h0000);
    chk_en = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Sequential fetch
    cyc();
    check("seq0_instr", IF_ID_instr, 16'h1123); check("seq0_pcn", IF_ID_PC_next, 16'h0002);
    check("seq0_tag", {8'd0, IF_ID_tag}, 16'h0000); check("seq0_valid", {15'd0, IF_ID_valid}, 16'h0001);
    cyc();
    check("seq1_instr", IF_ID_instr, 16'h2456); check("seq1_pcn", IF_ID_PC_next, 16'h0004);
    check("seq1_tag", {8'd0, IF_ID_tag}, 16'h0001);
    cyc();
    check("seq2_instr", IF_ID_instr, 16'h3789); check("seq2_pcn", IF_ID_PC_next, 16'h0006);
    check("seq2_tag", {8'd0, IF_ID_tag}, 16'h0002);

    // Stall at PC=0x0010
    for (int i = 0; i < 5; i++) cyc();
    check("pre_stall_addr", imem_addr, 16'h0010);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_addr", imem_addr, 16'h0010);
      check("stall_instr", IF_ID_instr, 16'h1007);
      check("stall_fid", {8'd0, fetch_id}, 16'h0008);
    end
    stall = 1'b0;
    cyc();
    check("resume_instr", IF_ID_instr, 16'h2ABC);
    check("resume_pcn", IF_ID_PC_next, 16'h0012);

    // Flush together with stall
    stall = 1'b1; flush = 1'b1; flush_target = 16'h0040;
    cyc();
    check("fs_addr", imem_addr, 16'h0040);
    check("fs_valid", {15'd0, IF_ID_valid}, 16'h0000);
    check("fs_instr", IF_ID_instr, 16'h0000);
    check("fs_fid", {8'd0, fetch_id}, 16'h0009);
    check("fs_pcn", IF_ID_PC_next, 16'h0012);

    // Halt at 0x0008
    mem[4] = 16'hF000;
    stall = 1'b0; flush_target = 16'h0008;
    cyc();
    flush = 1'b0;
    cyc();
    check("hlt_instr", IF_ID_instr, 16'hF000);
    check("hlt_valid", {15'd0, IF_ID_valid}, 16'h0001);
    check("hlt_halted", {15'd0, halted}, 16'h0001);
    check("hlt_addr", imem_addr, 16'h0008);
    cyc();
    check("hlt_bub_valid", {15'd0, IF_ID_valid}, 16'h0000);
    check("hlt_bub_addr", imem_addr, 16'h0008);
    check("hlt_bub_pcn", IF_ID_PC_next, 16'h000A);
    flush = 1'b1; flush_target = 16'h0020;
    cyc();
    flush = 1'b0;
    check("unhlt_halted", {15'd0, halted}, 16'h0000);
    check("unhlt_addr", imem_addr, 16'h0020);

    // Async reset while halted
    flush = 1'b1; flush_target = 16'h0008;
    cyc();
    flush = 1'b0;
    cyc();
    check("ar_pre_halted", {15'd0, halted}, 16'h0001);
    @(posedge clk);
    #2 rst = 1'b1; model_reset();
    #1;
    check("ar_halted", {15'd0, halted}, 16'h0000);
    check("ar_addr", imem_addr, RESET_PC);
    check("ar_valid", {15'd0, IF_ID_valid}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    check("post_rst_instr", IF_ID_instr, 16'h1123);
    check("post_rst_pcn", IF_ID_PC_next, 16'h0002);

    // Walk fetch_id up to 255, then wrap the PC
    flush = 1'b1; flush_target = 16'h0100;
    cyc();
    flush = 1'b0;
    n = 0;
    while (m_fid != 8'd255 && n < 400) begin
      cyc();
      n++;
    end
    check("fid_walk_reached", {8'd0, fetch_id}, 16'h00FF);
    flush = 1'b1; flush_target = 16'hFFFE;
    cyc();
    flush = 1'b0;
    cyc();
    check("wrap_addr", imem_addr, 16'h0000);
    check("wrap_pcn", IF_ID_PC_next, 16'h0000);
    check("wrap_tag", {8'd0, IF_ID_tag}, 16'h00FF);
    check("wrap_fid", {8'd0, fetch_id}, 16'h0000);
    check("wrap_instr", IF_ID_instr, 16'h1234);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rnd = $urandom;
      if ($urandom_range(0, 15) == 0) mem[m_pc[15:1]] = {HLT_OP, rnd[27:16]};
      else mem[m_pc[15:1]] = {4'($urandom_range(0, 14)), rnd[27:16]};
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      flush_target = {rnd[15:1], 1'b0};
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #2 rst = 1'b1; model_reset();
        #1 check("rand_ar_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        cyc();
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
